coverfloat_vec_tx: RTL and testbench
====================================

Name: coverfloat_vec_tx

Overview:
- Transmit end of the coverage-vector link.
- Accepts complete COVER_VECTOR_WIDTH-bit coverage vectors from the FPU-side capture logic, with fields already packed.
- Buffers them in a small FIFO and streams each one as a header beat followed by fixed-width payload beats, using valid/ready with a last marker.
- The far end reassembles the vectors and feeds the coverfloat_pkg-based coverage collector.

Parameters:
- VEC_W, 801, coverage vector width in bits; equals COVER_VECTOR_WIDTH.
- BEAT_W, 32, output beat width in bits; fixed at 32 because the header layout is 32 bits.
- FIFO_DEPTH, 2, vector buffer entries; power of 2, at least 2.
- NBEATS, ceil(VEC_W/BEAT_W) = 26, derived payload beat count; must be 255 or less.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- vec_valid  in  1  input vector valid
- vec_ready  out  1  input can accept a vector
- vec_data  in  VEC_W  packed coverage vector
- tx_valid  out  1  beat valid
- tx_ready  in  1  sink accepts beat
- tx_data  out  BEAT_W  beat payload
- tx_last  out  1  final beat of the current vector
- tx_busy  out  1  FIFO non-empty or FSM not IDLE
- vec_sent  out  16  count of fully transmitted vectors; wraps

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - FIFO is emptied; FSM goes to IDLE; sequence number is 0.
  - Outputs: vec_ready=0 while rst_n=0, then 1 from the first edge after deassertion; tx_valid=0; tx_last=0; tx_data=0; tx_busy=0; vec_sent=0.
- Input handshake:
  - A vector is written when vec_valid && vec_ready at a clk rise.
  - vec_ready = !full; it is registered-free and combinational from occupancy.
  - A write and a read in the same cycle while full is not permitted: vec_ready stays 0 when full, even if a pop occurs that cycle. No combinational path from tx_ready to vec_ready.
- FSM states:
  - IDLE: tx_valid=0. If the FIFO is non-empty, go to HDR next cycle.
  - HDR: tx_valid=1, tx_data = {seq[15:0], NBEATS[7:0], 8'hCF}, tx_last=0. On tx_ready, go to PAY with beat counter k=0.
  - PAY: tx_valid=1, tx_data = head[k*BEAT_W +: BEAT_W]. Bits above VEC_W-1 in the final beat are 0 (for VEC_W=801, beat 25 is {31'b0, head[800]}). tx_last = (k==NBEATS-1).
    - On tx_ready with k<NBEATS-1: k increments.
    - On tx_ready with k==NBEATS-1: pop FIFO, seq+1 (16-bit wrap), vec_sent+1 (wrap). If the FIFO still holds another entry, go directly to HDR (no idle bubble); otherwise go to IDLE.
- Latency: vector accepted at edge N into an empty block in IDLE → header presented (tx_valid=1) at edge N+1 → first possible payload at edge N+2. Minimum 27 beats per vector; back-to-back vectors stream at 100% beat utilisation when tx_ready is held high.
- AXI-style stability: while tx_valid=1 && !tx_ready, tx_data and tx_last hold stable. tx_valid never drops without a handshake.
- The FIFO head is not modified during transmission. Writes go to the tail only.
- Mid-stream reset: all state clears immediately. The partial vector is discarded, no last beat is emitted, and seq restarts at 0. The sink uses the header to resynchronise.
- tx_busy = (state!=IDLE) || !empty.

Test Plan:
- Single vector, tx_ready=1: vec_data has bit i = i[0] (alternating, 0 at LSB) and bit800=1 → header 0x0000_1ACF, payload beats 0–24 = 0xAAAA_AAAA, beat 25 = 0x0000_0001 with tx_last=1. vec_sent becomes 1; 27 consecutive valid cycles.
- Back-to-back: 3 vectors pushed with tx_ready=1 → headers seq 0,1,2 (0x0000_1ACF, 0x0001_1ACF, 0x0002_1ACF). No gap between a tx_last beat and the next header. vec_ready drops after 2 queued; vec_sent ends at 3.
- Backpressure: tx_ready random 30% duty during one vector → tx_data/tx_last are stable on every stalled cycle, and the reassembled 801 bits equal the input exactly.
- FIFO full: tx_ready=0, push vectors continuously → exactly FIFO_DEPTH (2) accepted and vec_ready=0 afterwards. Raising tx_ready drains both in order.
- Reset mid-stream: assert rst_n=0 at payload beat 10 → tx_valid=0 and vec_sent=0 immediately. After release, a new vector's header carries seq 0.
- Wrap: preload seq/vec_sent near 0xFFFF (force or send 65536 vectors) → next header seq=0x0000 and vec_sent wraps to 0.

Source files
------------

// File: rtl/coverfloat_vec_tx.sv
// coverfloat_vec_tx: buffers packed coverage vectors and streams each one as a
// header beat {seq, NBEATS, 8'hCF} followed by NBEATS payload beats, LSB first.
module coverfloat_vec_tx #(
   parameter int VEC_W      = 801,
   parameter int BEAT_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vec_valid,
   output logic              vec_ready,
   input  logic [VEC_W-1:0]  vec_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [BEAT_W-1:0] tx_data,
   output logic              tx_last,
   output logic              tx_busy,
   output logic [15:0]       vec_sent
);
   localparam int NBEATS = (VEC_W + BEAT_W - 1) / BEAT_W;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int PAD_W  = NBEATS * BEAT_W;

   typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

   state_t           state_q;
   logic [VEC_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
   logic [7:0]       k_q;
   logic [15:0]      seq_q, sent_q;
   logic             rdy_q, full, empty, push, pop, last;
   logic [PAD_W-1:0] head;

   // rdy_q holds vec_ready low until the first edge after reset release
   always_comb begin
      empty     = wr_q == rd_q;
      full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      vec_ready = rdy_q && !full;
      push      = vec_valid && vec_ready;
      last      = (state_q == PAY) && (k_q == 8'(NBEATS - 1));
      pop       = last && tx_ready;
      wr_d      = push ? wr_q + (AW+1)'(1) : wr_q;
      rd_d      = pop ? rd_q + (AW+1)'(1) : rd_q;
      head      = PAD_W'(mem_q[rd_q[AW-1:0]]);
      tx_valid  = state_q != IDLE;
      tx_last   = last;
      tx_data   = (state_q == HDR) ? {seq_q, 8'(NBEATS), 8'hCF} :
                  (state_q == PAY) ? head[k_q*BEAT_W +: BEAT_W] : '0;
      tx_busy   = tx_valid || !empty;
      vec_sent  = sent_q;
   end

   always_ff @(posedge clk)
      if (push) mem_q[wr_q[AW-1:0]] <= vec_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         k_q     <= '0;
         seq_q   <= '0;
         sent_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         case (state_q)
            IDLE: if (!empty) state_q <= HDR;
            HDR: if (tx_ready) begin
               state_q <= PAY;
               k_q     <= '0;
            end
            PAY: if (tx_ready) begin
               k_q <= k_q + 8'd1;
               if (last) begin
                  seq_q   <= seq_q + 16'd1;
                  sent_q  <= sent_q + 16'd1;
                  state_q <= (wr_d != rd_d) ? HDR : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_coverfloat_vec_tx.sv
// tb_coverfloat_vec_tx: scoreboard bench; accepted vectors queue their expected
// beats, and every beat handshake is popped and compared in order.
module tb_coverfloat_vec_tx;
   logic         clk = 1'b0, rst_n = 1'b0, vec_valid = 1'b0, tx_ready = 1'b0;
   logic [800:0] vec_data = '0;
   logic         vec_ready, tx_valid, tx_last, tx_busy;
   logic [31:0]  tx_data;
   logic [15:0]  vec_sent;
   int           checks = 0, errors = 0;
   logic [32:0]  exp_q[$], obs_q[$];
   logic [15:0]  tb_seq = '0;
   logic         stall = 1'b0;
   logic [32:0]  held = '0;

   always #5 clk = ~clk;

   coverfloat_vec_tx dut (
      .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .vec_data(vec_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_last(tx_last), .tx_busy(tx_busy), .vec_sent(vec_sent)
   );

   // inputs change just after posedge, so mid-cycle values are what the next edge sees
   always @(negedge clk) begin
      logic [831:0] pad;
      logic [32:0]  e;
      if (!rst_n) stall = 1'b0;
      else begin
         if (vec_valid && vec_ready) begin
            pad = 832'(vec_data);
            exp_q.push_back({1'b0, tb_seq, 8'd26, 8'hCF});
            for (int b = 0; b < 26; b++) exp_q.push_back({b == 25, pad[b*32 +: 32]});
            tb_seq++;
         end
         if (stall) begin
            checks++;
            if (!tx_valid || {tx_last, tx_data} !== held) begin
               errors++;
               $display("FAIL stall_hold got valid=%0b last_data=%h want valid=1 last_data=%h", tx_valid, {tx_last, tx_data}, held);
            end
         end
         stall = tx_valid && !tx_ready;
         held  = {tx_last, tx_data};
         if (tx_valid && tx_ready) begin
            obs_q.push_back({tx_last, tx_data});
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++;
            if ({tx_last, tx_data} !== e) begin
               errors++;
               $display("FAIL beat got last_data=%h want %h", {tx_last, tx_data}, e);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [800:0] rand_vec();
      logic [831:0] r;
      for (int b = 0; b < 26; b++) r[b*32 +: 32] = $urandom;
      return r[800:0];
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; vec_valid = 1'b0; tx_ready = 1'b0;
      step(2);
      exp_q.delete(); tb_seq = '0;
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic wait_drain(input int max);
      int t = 0;
      while ((exp_q.size() != 0 || tx_busy) && t < max) begin step(1); t++; end
      checks++;
      if (t >= max) begin errors++; $display("FAIL drain_timeout got %0d beats pending want 0", exp_q.size()); end
   endtask

   task automatic push_vec(input logic [800:0] v);
      int t = 0;
      vec_data = v; vec_valid = 1'b1;
      while (!vec_ready && t < 200) begin step(1); t++; end
      step(1);
      vec_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vec_valid = 1'b0; tx_ready = 1'b0;
      step(2);
      checks += 6;
      if (vec_ready !== 1'b0) begin errors++; $display("FAIL reset_vec_ready got %b want 0", vec_ready); end
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
      if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last got %b want 0", tx_last); end
      if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data got %h want 0", tx_data); end
      if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
      if (vec_sent !== 16'h0) begin errors++; $display("FAIL reset_vec_sent got %h want 0", vec_sent); end
      rst_n = 1'b1; exp_q.delete(); tb_seq = '0;
      #1;
      checks++;
      if (vec_ready !== 1'b0) begin errors++; $display("FAIL release_vec_ready got %b want 0", vec_ready); end
      step(1);
      checks++;
      if (vec_ready !== 1'b1) begin errors++; $display("FAIL first_edge_vec_ready got %b want 1", vec_ready); end
   endtask

   task automatic test_single();
      logic [800:0] v;
      int first = -1, lastc = -1, cnt = 0;
      for (int i = 0; i < 801; i++) v[i] = i[0];
      v[800] = 1'b1;
      obs_q.delete(); tx_ready = 1'b1;
      vec_data = v; vec_valid = 1'b1;
      step(1);
      vec_valid = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_idle_after_accept got %b want 0", tx_valid); end
      for (int c = 1; c <= 40; c++) begin
         step(1);
         if (tx_valid) begin cnt++; lastc = c; if (first < 0) first = c; end
      end
      checks += 4;
      if (first != 1) begin errors++; $display("FAIL single_hdr_latency got %0d want 1", first); end
      if (cnt != 27) begin errors++; $display("FAIL single_valid_cycles got %0d want 27", cnt); end
      if (lastc - first != 26) begin errors++; $display("FAIL single_contiguous got span %0d want 26", lastc - first); end
      if (vec_sent !== 16'd1) begin errors++; $display("FAIL single_vec_sent got %0d want 1", vec_sent); end
      checks++;
      if (obs_q.size() != 27) begin errors++; $display("FAIL single_beats got %0d want 27", obs_q.size()); end
      else begin
         checks += 4;
         if (obs_q[0] !== 33'h0_0000_1ACF) begin errors++; $display("FAIL single_hdr got %h want 000001acf", obs_q[0]); end
         if (obs_q[1] !== 33'h0_AAAA_AAAA) begin errors++; $display("FAIL single_beat0 got %h want 0aaaaaaaa", obs_q[1]); end
         if (obs_q[25] !== 33'h0_AAAA_AAAA) begin errors++; $display("FAIL single_beat24 got %h want 0aaaaaaaa", obs_q[25]); end
         if (obs_q[26] !== 33'h1_0000_0001) begin errors++; $display("FAIL single_beat25 got %h want 100000001", obs_q[26]); end
      end
   endtask

   task automatic test_back_to_back();
      int n = 0, t = 0, gaps = 0;
      logic acc, seen = 1'b0;
      do_reset();
      obs_q.delete(); tx_ready = 1'b1;
      while (n < 3 && t < 200) begin
         vec_data = rand_vec(); vec_valid = 1'b1; acc = vec_ready;
         step(1); t++;
         if (acc) begin
            n++;
            if (n == 2) begin
               checks++;
               if (vec_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", vec_ready); end
            end
         end
      end
      vec_valid = 1'b0;
      t = 0;
      while ((exp_q.size() != 0 || tx_busy) && t < 300) begin
         if (tx_valid) seen = 1'b1;
         else if (seen && exp_q.size() != 0) gaps++;
         step(1); t++;
      end
      checks += 3;
      if (gaps != 0) begin errors++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
      if (vec_sent !== 16'd3) begin errors++; $display("FAIL b2b_vec_sent got %0d want 3", vec_sent); end
      if (obs_q.size() != 81) begin errors++; $display("FAIL b2b_beats got %0d want 81", obs_q.size()); end
      else begin
         checks += 3;
         if (obs_q[0] !== 33'h0_0000_1ACF) begin errors++; $display("FAIL b2b_hdr0 got %h want 000001acf", obs_q[0]); end
         if (obs_q[27] !== 33'h0_0001_1ACF) begin errors++; $display("FAIL b2b_hdr1 got %h want 000011acf", obs_q[27]); end
         if (obs_q[54] !== 33'h0_0002_1ACF) begin errors++; $display("FAIL b2b_hdr2 got %h want 000021acf", obs_q[54]); end
      end
   endtask

   task automatic test_backpressure();
      logic [800:0] v = rand_vec();
      logic [831:0] r = '0;
      int t = 0;
      obs_q.delete(); tx_ready = 1'b0;
      push_vec(v);
      while ((exp_q.size() != 0 || tx_busy) && t < 2000) begin
         tx_ready = ($urandom_range(0, 9) < 3);
         step(1); t++;
      end
      tx_ready = 1'b1;
      checks++;
      if (obs_q.size() != 27) begin errors++; $display("FAIL bp_beats got %0d want 27", obs_q.size()); end
      else begin
         for (int b = 1; b < 27; b++) r[(b-1)*32 +: 32] = obs_q[b][31:0];
         checks++;
         if (r !== 832'(v)) begin errors++; $display("FAIL bp_reassembly got %h want %h", r[800:0], v); end
      end
   endtask

   task automatic test_fifo_full();
      int acc = 0;
      obs_q.delete(); tx_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         vec_data = rand_vec(); vec_valid = 1'b1;
         if (vec_ready) acc++;
         step(1);
      end
      vec_valid = 1'b0;
      checks += 2;
      if (acc != 2) begin errors++; $display("FAIL full_accepted got %0d want 2", acc); end
      if (vec_ready !== 1'b0) begin errors++; $display("FAIL full_vec_ready got %b want 0", vec_ready); end
      tx_ready = 1'b1;
      wait_drain(200);
      checks += 2;
      if (obs_q.size() != 54) begin errors++; $display("FAIL full_beats got %0d want 54", obs_q.size()); end
      if (vec_sent !== 16'd6) begin errors++; $display("FAIL full_vec_sent got %0d want 6", vec_sent); end
   endtask

   task automatic test_mid_reset();
      int t = 0;
      obs_q.delete(); tx_ready = 1'b1;
      push_vec(rand_vec());
      while (obs_q.size() < 11 && t < 100) begin step(1); t++; end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid got %b want 0", tx_valid); end
      if (tx_last !== 1'b0) begin errors++; $display("FAIL midrst_tx_last got %b want 0", tx_last); end
      if (vec_sent !== 16'd0) begin errors++; $display("FAIL midrst_vec_sent got %0d want 0", vec_sent); end
      exp_q.delete(); tb_seq = '0;
      step(2);
      rst_n = 1'b1;
      step(1);
      obs_q.delete();
      push_vec(rand_vec());
      wait_drain(200);
      checks += 2;
      if (obs_q.size() == 0 || obs_q[0] !== 33'h0_0000_1ACF) begin errors++; $display("FAIL midrst_hdr_seq0 got %0d beats first=%h want 000001acf", obs_q.size(), (obs_q.size() != 0) ? obs_q[0] : 33'h0); end
      if (vec_sent !== 16'd1) begin errors++; $display("FAIL midrst_vec_sent_after got %0d want 1", vec_sent); end
   endtask

   task automatic test_wrap();
      force dut.seq_q = 16'hFFFF;
      force dut.sent_q = 16'hFFFF;
      step(1);
      release dut.seq_q;
      release dut.sent_q;
      tb_seq = 16'hFFFF;
      obs_q.delete(); tx_ready = 1'b1;
      push_vec(rand_vec());
      wait_drain(200);
      checks += 2;
      if (obs_q.size() == 0 || obs_q[0] !== 33'h0_FFFF_1ACF) begin errors++; $display("FAIL wrap_hdr_ffff got %0d beats want first 0ffff1acf", obs_q.size()); end
      if (vec_sent !== 16'd0) begin errors++; $display("FAIL wrap_vec_sent got %0d want 0", vec_sent); end
      push_vec(rand_vec());
      wait_drain(200);
      checks += 2;
      if (obs_q.size() != 54 || obs_q[27] !== 33'h0_0000_1ACF) begin errors++; $display("FAIL wrap_hdr_0000 got %0d beats want 54 with header 000001acf", obs_q.size()); end
      if (vec_sent !== 16'd1) begin errors++; $display("FAIL wrap_vec_sent_after got %0d want 1", vec_sent); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_fifo_full();
      test_mid_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
